// File: rtl/turn_sequencer_pkg.sv
// Shared Connect-4 encodings for the turn sequencer, LED status display and win checker.
package turn_sequencer_pkg;

    localparam int unsigned COLS_DEF = 7;
    localparam int unsigned ROWS_DEF = 6;

    localparam logic [1:0] GAME_INIT = 2'b00;
    localparam logic [1:0] P1_TURN   = 2'b01;
    localparam logic [1:0] P2_TURN   = 2'b10;
    localparam logic [1:0] END_GAME  = 2'b11;

    localparam logic [1:0] STILL_PLAYING = 2'b00;
    localparam logic [1:0] P1_WINS       = 2'b01;
    localparam logic [1:0] P2_WINS       = 2'b10;
    localparam logic [1:0] TIE           = 2'b11;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_P1_WAIT,
        ST_P1_CHK,
        ST_P2_WAIT,
        ST_P2_CHK,
        ST_END
    } fsm_t;

    // Display-facing 2-bit state code; the WAIT and CHK phases of a turn share one code.
    function automatic logic [1:0] state_code(input fsm_t s);
        case (s)
            ST_INIT:               return GAME_INIT;
            ST_P1_WAIT, ST_P1_CHK: return P1_TURN;
            ST_P2_WAIT, ST_P2_CHK: return P2_TURN;
            default:               return END_GAME;
        endcase
    endfunction

endpackage

// File: rtl/turn_sequencer_column_heights.sv
// Per-column fill heights: sync clear, increment at index, combinational read and full flag.
module column_heights
    import turn_sequencer_pkg::*;
#(
    parameter int unsigned COLS  = COLS_DEF,
    parameter int unsigned ROWS  = ROWS_DEF,
    parameter int unsigned COL_W = 3,
    parameter int unsigned ROW_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic [COL_W-1:0] idx,
    output logic [ROW_W-1:0] height,
    output logic             full
);

    logic [ROW_W-1:0] heights [COLS];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int unsigned i = 0; i < COLS; i++) heights[i] <= '0;
        end else if (inc) begin
            for (int unsigned i = 0; i < COLS; i++)
                if (32'(idx) == i) heights[i] <= heights[i] + 1'b1;
        end
    end

    // Out-of-range indices read as height 0; the caller rejects them separately.
    always_comb begin
        height = '0;
        for (int unsigned i = 0; i < COLS; i++)
            if (32'(idx) == i) height = heights[i];
    end

    assign full = (32'(height) >= ROWS);

endmodule

// File: rtl/turn_sequencer.sv
// Connect-4 turn sequencer: turn FSM, move counter, placement write and win-check handshake.
module turn_sequencer
    import turn_sequencer_pkg::*;
#(
    parameter int unsigned COLS  = COLS_DEF,
    parameter int unsigned ROWS  = ROWS_DEF,
    parameter int unsigned COL_W = 3,
    parameter int unsigned ROW_W = 3,
    parameter int unsigned MOV_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [COL_W-1:0] col_sel,
    input  logic             drop,
    input  logic             chk_done,
    input  logic             chk_win,
    output logic [1:0]       state,
    output logic [1:0]       game_status,
    output logic             place_we,
    output logic [COL_W-1:0] place_col,
    output logic [ROW_W-1:0] place_row,
    output logic             place_p2,
    output logic             chk_req,
    output logic             move_err,
    output logic [MOV_W-1:0] move_count
);

    fsm_t             fsm;
    logic [ROW_W-1:0] cur_height;
    logic             col_full;
    logic             col_ok;
    logic             in_wait;
    logic             accept;

    assign col_ok  = (32'(col_sel) < COLS) && !col_full;
    assign in_wait = (fsm == ST_P1_WAIT) || (fsm == ST_P2_WAIT);
    assign accept  = !reset && !start && in_wait && drop && col_ok;

    column_heights #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_heights (
        .clk    (clk),
        .reset  (reset),
        .clear  (start),
        .inc    (accept),
        .idx    (col_sel),
        .height (cur_height),
        .full   (col_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm         <= ST_INIT;
            state       <= GAME_INIT;
            game_status <= STILL_PLAYING;
            place_we    <= 1'b0;
            place_col   <= '0;
            place_row   <= '0;
            place_p2    <= 1'b0;
            chk_req     <= 1'b0;
            move_err    <= 1'b0;
            move_count  <= '0;
        end else begin
            place_we <= 1'b0;
            move_err <= 1'b0;
            if (start) begin
                chk_req     <= 1'b0;
                move_count  <= '0;
                game_status <= STILL_PLAYING;
                if (fsm == ST_INIT) begin
                    fsm   <= ST_P1_WAIT;
                    state <= state_code(ST_P1_WAIT);
                end else begin
                    fsm   <= ST_INIT;
                    state <= state_code(ST_INIT);
                end
            end else begin
                case (fsm)
                    ST_P1_WAIT, ST_P2_WAIT: begin
                        if (drop) begin
                            if (col_ok) begin
                                place_we   <= 1'b1;
                                place_col  <= col_sel;
                                place_row  <= cur_height;
                                place_p2   <= (fsm == ST_P2_WAIT);
                                chk_req    <= 1'b1;
                                move_count <= move_count + 1'b1;
                                fsm        <= (fsm == ST_P1_WAIT) ? ST_P1_CHK : ST_P2_CHK;
                            end else begin
                                move_err <= 1'b1;
                            end
                        end
                    end
                    ST_P1_CHK, ST_P2_CHK: begin
                        if (chk_done) begin
                            chk_req <= 1'b0;
                            // move_count already includes the piece under check, so a win on it outranks the tie.
                            if (chk_win) begin
                                fsm         <= ST_END;
                                state       <= state_code(ST_END);
                                game_status <= (fsm == ST_P2_CHK) ? P2_WINS : P1_WINS;
                            end else if (32'(move_count) == COLS * ROWS) begin
                                fsm         <= ST_END;
                                state       <= state_code(ST_END);
                                game_status <= TIE;
                            end else if (fsm == ST_P1_CHK) begin
                                fsm   <= ST_P2_WAIT;
                                state <= state_code(ST_P2_WAIT);
                            end else begin
                                fsm   <= ST_P1_WAIT;
                                state <= state_code(ST_P1_WAIT);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_turn_sequencer.sv
// Self-checking bench for turn_sequencer: behavioural game model plus placement scoreboard.
module tb_turn_sequencer;

    localparam int COLS = 7;
    localparam int ROWS = 6;

    localparam int M_INIT = 0, M_P1W = 1, M_P1C = 2, M_P2W = 3, M_P2C = 4, M_END = 5;

    logic       clk = 1'b0;
    logic       reset, start, drop, chk_done, chk_win;
    logic [2:0] col_sel;
    logic [1:0] state, game_status;
    logic       place_we, place_p2, chk_req, move_err;
    logic [2:0] place_col, place_row;
    logic [5:0] move_count;

    turn_sequencer #(
        .COLS  (7),
        .ROWS  (6),
        .COL_W (3),
        .ROW_W (3),
        .MOV_W (6)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .col_sel     (col_sel),
        .drop        (drop),
        .chk_done    (chk_done),
        .chk_win     (chk_win),
        .state       (state),
        .game_status (game_status),
        .place_we    (place_we),
        .place_col   (place_col),
        .place_row   (place_row),
        .place_p2    (place_p2),
        .chk_req     (chk_req),
        .move_err    (move_err),
        .move_count  (move_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int col;
        int row;
        bit p2;
    } place_t;

    typedef struct {
        int col;
        bit win;
        int exp_state;
        int exp_status;
    } vec_t;

    place_t exp_q[$];
    int     checks = 0;
    int     errors = 0;

    int m_fsm, m_status, m_mc;
    int m_h[COLS];
    bit m_err;

    function automatic int m_state();
        case (m_fsm)
            M_INIT:       return 0;
            M_P1W, M_P1C: return 1;
            M_P2W, M_P2C: return 2;
            default:      return 3;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        m_fsm = M_INIT; m_status = 0; m_mc = 0; m_err = 0;
        for (int i = 0; i < COLS; i++) m_h[i] = 0;
        exp_q.delete();
    endtask

    task automatic m_start();
        m_fsm    = (m_fsm == M_INIT) ? M_P1W : M_INIT;
        m_status = 0;
        m_mc     = 0;
        for (int i = 0; i < COLS; i++) m_h[i] = 0;
    endtask

    task automatic verify(input string tag);
        place_t e;
        bit     want_we;
        want_we = (exp_q.size() > 0);
        check({tag, " place_we"}, int'(place_we), int'(want_we));
        if (want_we) begin
            e = exp_q.pop_front();
            if (place_we) begin
                check({tag, " place_col"}, int'(place_col), e.col);
                check({tag, " place_row"}, int'(place_row), e.row);
                check({tag, " place_p2"}, int'(place_p2), int'(e.p2));
            end
        end
        check({tag, " move_err"}, int'(move_err), int'(m_err));
        check({tag, " state"}, int'(state), m_state());
        check({tag, " game_status"}, int'(game_status), m_status);
        check({tag, " move_count"}, int'(move_count), m_mc);
        check({tag, " chk_req"}, int'(chk_req), int'(m_fsm == M_P1C || m_fsm == M_P2C));
    endtask

    task automatic do_drop(input int c, input string tag);
        m_err = 0;
        if (m_fsm == M_P1W || m_fsm == M_P2W) begin
            if (c < COLS && m_h[c] < ROWS) begin
                exp_q.push_back('{col: c, row: m_h[c], p2: (m_fsm == M_P2W)});
                m_h[c]++;
                m_mc++;
                m_fsm = (m_fsm == M_P1W) ? M_P1C : M_P2C;
            end else begin
                m_err = 1;
            end
        end
        col_sel = 3'(c);
        drop    = 1'b1;
        tick();
        drop    = 1'b0;
        verify(tag);
    endtask

    task automatic do_chk(input bit win, input string tag);
        m_err = 0;
        if (m_fsm == M_P1C || m_fsm == M_P2C) begin
            if (win) begin
                m_status = (m_fsm == M_P2C) ? 2 : 1;
                m_fsm    = M_END;
            end else if (m_mc == COLS * ROWS) begin
                m_status = 3;
                m_fsm    = M_END;
            end else begin
                m_fsm = (m_fsm == M_P1C) ? M_P2W : M_P1W;
            end
        end
        chk_done = 1'b1;
        chk_win  = win;
        tick();
        chk_done = 1'b0;
        chk_win  = 1'b0;
        verify(tag);
    endtask

    task automatic do_start(input string tag);
        m_err = 0;
        m_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        verify(tag);
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{col: 1, win: 1'b0, exp_state: 2, exp_status: 0};
        vecs[1] = '{col: 1, win: 1'b0, exp_state: 1, exp_status: 0};
        vecs[2] = '{col: 2, win: 1'b0, exp_state: 2, exp_status: 0};
        vecs[3] = '{col: 2, win: 1'b1, exp_state: 3, exp_status: 2};

        reset = 1'b1; start = 1'b0; drop = 1'b0; chk_done = 1'b0; chk_win = 1'b0; col_sel = '0;
        m_reset();
        tick();
        tick();
        verify("reset");
        reset = 1'b0;

        // 1: start from INIT
        do_start("t1 start");
        check("t1 state p1", int'(state), 1);

        // 2: basic placement, drop ignored during check, stray chk_done ignored in WAIT
        do_chk(1'b0, "t2 stray chk");
        do_drop(3, "t2 p1 drop");
        do_drop(5, "t2 drop in chk");
        do_chk(1'b0, "t2 chk p1");
        check("t2 state p2", int'(state), 2);
        do_drop(3, "t2 p2 drop");
        check("t2 p2 row", int'(place_row), 1);
        do_chk(1'b0, "t2 chk p2");

        // 3: fill column 0, then overflow and out-of-range column
        for (int i = 0; i < ROWS; i++) begin
            do_drop(0, "t3 fill");
            do_chk(1'b0, "t3 fill chk");
        end
        do_drop(0, "t3 full col");
        check("t3 err pulse", int'(move_err), 1);
        do_drop(7, "t3 bad col");
        check("t3 state kept", int'(state), 1);

        // 4: table-driven game ending in a P2 win
        for (int i = 0; i < 4; i++) begin
            do_drop(vecs[i].col, "t4 drop");
            do_chk(vecs[i].win, "t4 chk");
            check("t4 vec state", int'(state), vecs[i].exp_state);
            check("t4 vec status", int'(game_status), vecs[i].exp_status);
        end
        do_drop(4, "t4 drop in end");
        do_chk(1'b1, "t4 chk in end");
        do_start("t4 restart");
        check("t4 init state", int'(state), 0);

        // 5: full board, tie; then win on the final piece
        do_start("t5 start");
        for (int i = 0; i < COLS * ROWS; i++) begin
            do_drop(i / ROWS, "t5 drop");
            do_chk(1'b0, "t5 chk");
        end
        check("t5 tie status", int'(game_status), 3);
        check("t5 tie state", int'(state), 3);
        do_start("t5 to init");
        do_start("t5 start2");
        for (int i = 0; i < COLS * ROWS; i++) begin
            do_drop(i / ROWS, "t5b drop");
            do_chk(i == COLS * ROWS - 1, "t5b chk");
        end
        check("t5 last win status", int'(game_status), 2);

        // 6: start beats drop; reset in the middle of a check
        do_start("t6 to init");
        do_start("t6 start");
        m_err = 0;
        m_start();
        col_sel = 3'd2; start = 1'b1; drop = 1'b1;
        tick();
        start = 1'b0; drop = 1'b0;
        verify("t6 start+drop");
        do_start("t6 start again");
        do_drop(2, "t6 drop");
        reset = 1'b1;
        tick();
        m_reset();
        verify("t6 mid reset");
        check("t6 place_col", int'(place_col), 0);
        check("t6 place_row", int'(place_row), 0);
        check("t6 place_p2", int'(place_p2), 0);
        reset = 1'b0;
        do_start("t6 post start");
        do_drop(2, "t6 post drop");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
